// File: rtl/time_display_pkg.sv
// rtl/time_display_pkg.sv - shared segment constants, frame geometry and FSM states for the time display back-end
package time_display_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_DP_BIT = 7;
  localparam int FRAME_W    = 48;
  localparam int IDX_W      = 6;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  // Anything outside 0-9 shows a dash so corrupted counter values stay visible
  function automatic logic [7:0] seg7_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/time_shift_out_if.sv
// rtl/time_shift_out_if.sv - request side and 3-wire serial side of the time display back-end
interface time_shift_out_if;
  logic       update_i;
  logic       synced_i;
  logic [1:0] hour_h_i;
  logic [3:0] hour_l_i;
  logic [2:0] minute_h_i;
  logic [3:0] minute_l_i;
  logic [2:0] second_h_i;
  logic [3:0] second_l_i;
  logic       sclk_o;
  logic       sdata_o;
  logic       latch_o;
  logic       busy_o;

  modport slave (
    input  update_i, synced_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i, second_h_i, second_l_i,
    output sclk_o, sdata_o, latch_o, busy_o
  );

  modport master (
    output update_i, synced_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i, second_h_i, second_l_i,
    input  sclk_o, sdata_o, latch_o, busy_o
  );
endinterface

// File: rtl/seg7_encoder.sv
// rtl/seg7_encoder.sv - one digit to {dp,g,f,e,d,c,b,a}, with optional blanking
module seg7_encoder
  import time_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = seg7_of(digit);
    seg[SEG_DP_BIT] = dp;
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/time_shift_out.sv
// rtl/time_shift_out.sv - encodes hh:mm:ss to a 48-bit 7-segment frame and shifts it into a 74HC595 chain
module time_shift_out
  import time_display_pkg::*;
#(
  parameter int CLK_DIV            = 1,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  time_shift_out_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [7:0]         seg_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] shadow;
  logic [IDX_W-1:0]   bit_idx;
  logic [DIV_W-1:0]   div_cnt;
  logic               div_done;
  logic               pending;
  logic               sclk_q, sdata_q, latch_q, busy_q;
  state_t             state;

  seg7_encoder u_enc_hh (.digit({2'b00, bus.hour_h_i}),
                         .blank(BLANK_LEADING_ZERO && (bus.hour_h_i == 2'd0)),
                         .dp(1'b0), .seg(seg_hh));
  seg7_encoder u_enc_hl (.digit(bus.hour_l_i), .blank(1'b0), .dp(bus.synced_i), .seg(seg_hl));
  seg7_encoder u_enc_mh (.digit({1'b0, bus.minute_h_i}), .blank(1'b0), .dp(1'b0), .seg(seg_mh));
  seg7_encoder u_enc_ml (.digit(bus.minute_l_i), .blank(1'b0), .dp(bus.synced_i), .seg(seg_ml));
  seg7_encoder u_enc_sh (.digit({1'b0, bus.second_h_i}), .blank(1'b0), .dp(1'b0), .seg(seg_sh));
  seg7_encoder u_enc_sl (.digit(bus.second_l_i), .blank(1'b0), .dp(1'b0), .seg(seg_sl));

  assign frame    = {seg_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl};
  assign div_done = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Requests during a transfer collapse into one follow-up frame
      if (state != IDLE && bus.update_i) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.update_i || pending) begin
            shadow  <= frame;
            pending <= 1'b0;
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= frame[FRAME_W-1];
            div_cnt <= '0;
            bit_idx <= IDX_W'(FRAME_W - 1);
            state   <= LOW;
          end
        end
        LOW: begin
          if (div_done) begin
            div_cnt <= '0;
            sclk_q  <= 1'b1;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_done) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
            if (bit_idx != '0) begin
              bit_idx <= bit_idx - IDX_W'(1);
              sdata_q <= shadow[bit_idx - IDX_W'(1)];
              state   <= LOW;
            end else begin
              sdata_q <= 1'b0;
              latch_q <= 1'b1;
              state   <= LATCH;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_done) begin
            div_cnt <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk_o  = sclk_q;
  assign bus.sdata_o = sdata_q;
  assign bus.latch_o = latch_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_time_shift_out.sv
// tb/tb_time_shift_out.sv - scoreboarded bench with a 74HC595 chain model behind two DUT configurations
module tb_time_shift_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_shift_out_if bus_a ();
  time_shift_out_if bus_b ();

  time_shift_out #(.CLK_DIV(1), .BLANK_LEADING_ZERO(1'b1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  time_shift_out #(.CLK_DIV(3), .BLANK_LEADING_ZERO(1'b0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [1:0] sclk_v, sdata_v, latch_v, busy_v;
  assign sclk_v  = {bus_b.sclk_o,  bus_a.sclk_o};
  assign sdata_v = {bus_b.sdata_o, bus_a.sdata_o};
  assign latch_v = {bus_b.latch_o, bus_a.latch_o};
  assign busy_v  = {bus_b.busy_o,  bus_a.busy_o};

  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];

  logic [1:0]  sclk_p = '0, latch_p = '0, busy_p = '0;
  logic [47:0] sr [2];
  int rises[2], busy_run[2], last_busy_run[2], idle_run[2], last_gap[2];
  int hi_run[2], lo_run[2], bad_half[2], overlap[2], latches[2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // 595 chain model and timing monitor, sampled on the falling clock edge
  initial begin
    for (int i = 0; i < 2; i++) begin
      sr[i] = '0; rises[i] = 0; busy_run[i] = 0; last_busy_run[i] = 0; idle_run[i] = 0;
      last_gap[i] = 0; hi_run[i] = 0; lo_run[i] = 0; bad_half[i] = 0; overlap[i] = 0; latches[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          rises[i] = 0; busy_run[i] = 0; idle_run[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
        end
        sclk_p = '0; latch_p = '0; busy_p = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (busy_v[i] && !busy_p[i]) begin
            last_gap[i] = idle_run[i];
            idle_run[i] = 0;
            busy_run[i] = 0;
            rises[i]    = 0;
          end
          if (!busy_v[i] && busy_p[i]) last_busy_run[i] = busy_run[i];
          if (busy_v[i]) busy_run[i]++; else idle_run[i]++;
          if (sclk_v[i] && latch_v[i]) overlap[i]++;
          if (sclk_v[i] && !sclk_p[i]) begin
            sr[i] = {sr[i][46:0], sdata_v[i]};
            rises[i]++;
            if (lo_run[i] != div_of(i)) bad_half[i]++;
            lo_run[i] = 0;
          end
          if (!sclk_v[i] && sclk_p[i]) begin
            if (hi_run[i] != div_of(i)) bad_half[i]++;
            hi_run[i] = 0;
          end
          if (sclk_v[i]) hi_run[i]++;
          else if (busy_v[i] && !latch_v[i]) lo_run[i]++;
          if (latch_v[i] && !latch_p[i]) begin
            logic        have;
            logic [47:0] e;
            latches[i]++;
            check($sformatf("sclk_rises_%0d", i), rises[i], 48);
            have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
            check($sformatf("latch_expected_%0d", i), have, 1'b1);
            if (have) begin
              e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("frame_%0d", i), sr[i], e);
            end
          end
          sclk_p[i]  = sclk_v[i];
          latch_p[i] = latch_v[i];
          busy_p[i]  = busy_v[i];
        end
      end
    end
  end

  task automatic set_digits(input int i, input logic [1:0] hh, input logic [3:0] hl,
                            input logic [2:0] mh, input logic [3:0] ml,
                            input logic [2:0] sh, input logic [3:0] sl, input logic s);
    if (i == 0) begin
      bus_a.hour_h_i = hh; bus_a.hour_l_i = hl; bus_a.minute_h_i = mh;
      bus_a.minute_l_i = ml; bus_a.second_h_i = sh; bus_a.second_l_i = sl; bus_a.synced_i = s;
    end else begin
      bus_b.hour_h_i = hh; bus_b.hour_l_i = hl; bus_b.minute_h_i = mh;
      bus_b.minute_l_i = ml; bus_b.second_h_i = sh; bus_b.second_l_i = sl; bus_b.synced_i = s;
    end
  endtask

  task automatic upd_pulse(input int i);
    @(negedge clk);
    if (i == 0) bus_a.update_i = 1'b1; else bus_b.update_i = 1'b1;
    @(negedge clk);
    if (i == 0) bus_a.update_i = 1'b0; else bus_b.update_i = 1'b0;
  endtask

  task automatic start(input int i, input logic [1:0] hh, input logic [3:0] hl,
                       input logic [2:0] mh, input logic [3:0] ml,
                       input logic [2:0] sh, input logic [3:0] sl, input logic s,
                       input logic push, input logic [47:0] exp_frame);
    @(negedge clk);
    set_digits(i, hh, hl, mh, ml, sh, sl, s);
    if (i == 0) bus_a.update_i = 1'b1; else bus_b.update_i = 1'b1;
    if (push) begin
      if (i == 0) exp_q0.push_back(exp_frame); else exp_q1.push_back(exp_frame);
    end
    @(negedge clk);
    if (i == 0) bus_a.update_i = 1'b0; else bus_b.update_i = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int bound);
    int n = 0;
    while (busy_v[i] && n < bound) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_timeout_%0d", i), busy_v[i], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int saved_latches;
    bus_a.update_i = 1'b0;
    bus_b.update_i = 1'b0;
    set_digits(0, 0, 0, 0, 0, 0, 0, 0);
    set_digits(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {bus_a.sclk_o, bus_a.sdata_o, bus_a.latch_o, bus_a.busy_o}, 4'b0);
    check("reset_outputs_b", {bus_b.sclk_o, bus_b.sdata_o, bus_b.latch_o, bus_b.busy_o}, 4'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start(0, 2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 1'b1, 1'b1, 48'h06DB4FE66D7D);
    wait_idle(0, 200);
    check("busy_len_div1", last_busy_run[0], 97);

    start(0, 2'd0, 4'd9, 3'd0, 4'd5, 3'd0, 4'd7, 1'b0, 1'b1, 48'h006F3F6D3F07);
    wait_idle(0, 200);
    start(0, 2'd1, 4'd2, 3'd3, 4'd12, 3'd5, 4'd6, 1'b1, 1'b1, 48'h06DB4FC06D7D);
    wait_idle(0, 200);
    start(0, 2'd1, 4'd2, 3'd3, 4'd12, 3'd5, 4'd6, 1'b0, 1'b1, 48'h065B4F406D7D);
    wait_idle(0, 200);

    start(1, 2'd0, 4'd9, 3'd0, 4'd5, 3'd0, 4'd7, 1'b0, 1'b1, 48'h3F6F3F6D3F07);
    wait_idle(1, 600);
    check("busy_len_div3", last_busy_run[1], 291);

    start(1, 2'd2, 4'd0, 3'd4, 4'd7, 3'd1, 4'd3, 1'b1, 1'b1, 48'h5BBF6687064F);
    repeat (20) @(negedge clk);
    set_digits(1, 2'd1, 4'd1, 3'd1, 4'd1, 3'd1, 4'd1, 1'b1);
    upd_pulse(1);
    repeat (40) @(negedge clk);
    set_digits(1, 2'd0, 4'd8, 3'd0, 4'd8, 3'd0, 4'd8, 1'b1);
    upd_pulse(1);
    repeat (40) @(negedge clk);
    set_digits(1, 2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8, 1'b0);
    upd_pulse(1);
    exp_q1.push_back(48'h5B4F6D6F6D7F);
    check("busy_mid_frame", busy_v[1], 1'b1);
    wait_idle(1, 600);
    @(negedge clk);
    check("follow_up_started", busy_v[1], 1'b1);
    wait_idle(1, 600);
    check("busy_gap", last_gap[1], 1);
    repeat (30) @(negedge clk);
    check("no_third_frame", busy_v[1], 1'b0);
    check("latches_b", latches[1], 3);

    saved_latches = latches[0];
    start(0, 2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 1'b1, 1'b0, 48'h0);
    n = 0;
    while (!sclk_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_high", sclk_v[0], 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_a", {bus_a.sclk_o, bus_a.sdata_o, bus_a.latch_o, bus_a.busy_o}, 4'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_sclk_after_reset", rises[0], 0);
    check("idle_after_reset", busy_v[0], 1'b0);
    check("no_partial_latch", latches[0], saved_latches);
    check("latches_a", latches[0], 4);

    check("latch_sclk_overlap", overlap[0] + overlap[1], 0);
    check("half_period_div1", bad_half[0], 0);
    check("half_period_div3", bad_half[1], 0);
    check("queue_empty_a", exp_q0.size(), 0);
    check("queue_empty_b", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_shift_out.md
Name: time_shift_out

Overview:
- Display back-end downstream of the digits counter.
- Accepts a request with the six current time digits (hh:mm:ss) and encodes each digit to 7-segment plus decimal point.
- Shifts the resulting 48-bit frame out MSB-first over a 3-wire serial bus (sclk/sdata/latch) to an external chain of six 74HC595-style shift registers, then pulses latch.
- Uses only 3 output pins, which suits the limited io_out budget.

Parameters:
- CLK_DIV, 1: system clocks per sclk half-period. Must be ≥1.
- BLANK_LEADING_ZERO, 1: when 1, hour_h==0 is sent as 0x00 (blank) instead of "0".

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- update_i  input  1  single-cycle request to send a new frame
- synced_i  input  1  time is radio-synchronised; lights colon DPs
- hour_h_i  input  2  hour tens digit
- hour_l_i  input  4  hour units digit
- minute_h_i  input  3  minute tens digit
- minute_l_i  input  4  minute units digit
- second_h_i  input  3  second tens digit
- second_l_i  input  4  second units digit
- sclk_o  output  1  serial clock; external shift on rising edge
- sdata_o  output  1  serial data
- latch_o  output  1  storage-register latch pulse, active-high
- busy_o  output  1  frame transfer in progress

Behaviour:
- Reset (asynchronous, active-high): sclk_o=0, sdata_o=0, latch_o=0, busy_o=0, pending=0, state IDLE.
- Segment byte format is {dp,g,f,e,d,c,b,a}, active-high.
  - Digits 0-9 encode to 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Any value >9 encodes to 0x40 (dash).
  - Leading-zero blanking applies to hour_h only.
- DP (bit7) is set on hour_l and minute_l bytes iff synced_i=1 at capture.
- Frame is 48 bits, sent MSB-first: hour_h, hour_l, minute_h, minute_l, second_h, second_l. Bit 47 = hour_h dp.
- States: IDLE, LOW, HIGH, LATCH. A divider counter runs 0..CLK_DIV-1; a bit index runs 47..0.
- IDLE + update_i sampled high at edge N:
  - All digit inputs and synced_i are captured into a 48-bit shadow register.
  - busy_o=1, state LOW, sdata_o=bit47, sclk_o=0.
  - Digit inputs are don't-care after capture.
- LOW: after CLK_DIV cycles, sclk_o→1, state HIGH. sdata_o is stable throughout LOW and HIGH.
- HIGH: after CLK_DIV cycles, sclk_o→0.
  - If index>0: index−1, sdata_o updates to the next bit on the same edge, state LOW.
  - If index==0: state LATCH, latch_o=1, sdata_o=0.
- LATCH: after CLK_DIV cycles, latch_o=0, busy_o=0, state IDLE.
- Timing: edge-to-edge from capture to busy_o falling is 97*CLK_DIV cycles. Exactly 48 sclk rising edges per frame. latch_o is high for CLK_DIV cycles and never overlaps sclk_o high.
- update_i while busy: sets pending; the running frame is not disturbed and multiple requests merge into one. In IDLE with pending=1, a capture occurs as if update_i were high, pending clears, and fresh inputs are captured. busy_o is therefore low for exactly one cycle between back-to-back frames.
- update_i in the same cycle the LATCH→IDLE transition occurs: sets pending; it is serviced on the next edge.
- Reset mid-frame: all outputs drop immediately (asynchronously). latch_o is never asserted for a partial frame.

Decomposition:
- Shared package (time_display_pkg):
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - DP bit index.
  - Frame width constant (48).
  - State enum {IDLE, LOW, HIGH, LATCH}.
- One natural sub-module, seg7_encoder: a 4-bit digit plus blank flag and dp in, 8-bit segment byte out. It is purely combinational and instantiated six times ahead of the shadow register.

Test Plan:
- Reset check: assert rst_i mid-HIGH state → all outputs 0 on the same cycle. After release, no sclk edges until update_i.
- CLK_DIV=1, 12:34:56, synced_i=1, pulse update_i → shifted bytes 06 DB 4F E6 6D 7D, then one latch pulse. busy_o high for exactly 97 cycles. 48 sclk rising edges counted.
- 09:05:07, synced_i=0, BLANK_LEADING_ZERO=1 → bytes 00 6F 3F 6D 3F 07. With BLANK_LEADING_ZERO=0, the first byte is 3F.
- Out-of-range minute_l=12 → that byte is 0x40 (0xC0 if synced_i=1). All other bytes unaffected.
- CLK_DIV=3, three update_i pulses during one frame, digits changed mid-frame → the first frame carries the original values. Exactly one follow-up frame starts after a one-cycle busy_o gap, carrying the values present at that capture. sclk half-period is 3 cycles.
- Latch/sclk relation: scoreboard the 595 model output after each latch → it equals the expected frame. latch_o and sclk_o are never high together.
